// File: rtl/scaler_h_ctrl.sv
// Horizontal scaler step sequencer: divides in/out widths, applies at frame start.
// Optional macro SCALER_H_CTRL_ROUND_EN selects round-to-nearest division.
module scaler_h_ctrl #(
    parameter int PIXEL_STEP = 4096,
    parameter int WIDTH_W    = 16,
    parameter int STEP_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH_W-1:0] cfg_in_width,
    input  logic [WIDTH_W-1:0] cfg_out_width,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic               de_i,
    input  logic               vs_i,
    output logic [STEP_W-1:0]  scale_step_h,
    output logic               step_upd,
    output logic               pending,
    output logic               busy,
    output logic               cfg_err
);

    localparam int SH = $clog2(PIXEL_STEP);
`ifdef SCALER_H_CTRL_ROUND_EN
    localparam int DW = WIDTH_W + SH + 1;
`else
    localparam int DW = WIDTH_W + SH;
`endif
    localparam int RW = WIDTH_W + 1;
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        WAIT_FRAME
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0]      quo_q;
    logic [RW-1:0]      rem_q;
    logic [WIDTH_W-1:0] dvs_q;
    logic [CW-1:0]      cnt_q;
    logic [STEP_W-1:0]  pend_q;
    logic [STEP_W-1:0]  step_q;
    logic               upd_q;
    logic               err_q;

    logic               accept;
    logic               last;
    logic               apply;
    logic [RW-1:0]      rem_sh;
    logic [RW-1:0]      rem_nx;
    logic               ge;
    logic [DW-1:0]      quo_nx;
    logic [DW-1:0]      dvd_ld;
    logic               hi_set;
    logic               q_zero;

    assign accept = cfg_valid && (state_q == IDLE);
    assign last   = (cnt_q == CW'(DW - 1));
    assign apply  = (state_q == WAIT_FRAME) && de_i && vs_i;

`ifdef SCALER_H_CTRL_ROUND_EN
    assign dvd_ld = {1'b0, cfg_in_width, {SH{1'b0}}}
                  + DW'(cfg_out_width >> 1);
`else
    assign dvd_ld = {cfg_in_width, {SH{1'b0}}};
`endif

    // Remainder stays below the divisor, so dropping its top bit is lossless
    assign rem_sh = RW'({rem_q, quo_q[DW-1]});
    assign ge     = rem_sh >= {1'b0, dvs_q};
    assign rem_nx = ge ? rem_sh - {1'b0, dvs_q} : rem_sh;
    assign quo_nx = {quo_q[DW-2:0], ge};
    assign hi_set = |quo_nx[DW-1:STEP_W];
    assign q_zero = (quo_nx == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && (cfg_out_width != '0)) state_d = DIV;
            end
            DIV: begin
                if (last) state_d = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (de_i && vs_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            pend_q <= '0;
            step_q <= STEP_W'(PIXEL_STEP);
            upd_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (accept) begin
                err_q <= (cfg_out_width == '0);
                dvs_q <= cfg_out_width;
                quo_q <= dvd_ld;
                rem_q <= '0;
                cnt_q <= '0;
            end
            if (state_q == DIV) begin
                quo_q <= quo_nx;
                rem_q <= rem_nx;
                cnt_q <= cnt_q + 1'b1;
                if (last) begin
                    if (hi_set)      pend_q <= '1;
                    else if (q_zero) pend_q <= STEP_W'(1);
                    else             pend_q <= quo_nx[STEP_W-1:0];
                    if (hi_set || q_zero) err_q <= 1'b1;
                end
            end
            if (apply) begin
                step_q <= pend_q;
                upd_q  <= 1'b1;
            end
        end
    end

    assign cfg_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign pending      = (state_q == WAIT_FRAME);
    assign scale_step_h = step_q;
    assign step_upd     = upd_q;
    assign cfg_err      = err_q;

endmodule

// File: tb/tb_scaler_h_ctrl.sv
// Directed bench for scaler_h_ctrl: step values, frame-start apply, errors, reset.
module tb_scaler_h_ctrl;

`ifdef SCALER_H_CTRL_ROUND_EN
    localparam int DW   = 29;
    localparam int EXP2 = 2731;
`else
    localparam int DW   = 28;
    localparam int EXP2 = 2730;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cfg_in_width;
    logic [15:0] cfg_out_width;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        de_i;
    logic        vs_i;
    logic [15:0] scale_step_h;
    logic        step_upd;
    logic        pending;
    logic        busy;
    logic        cfg_err;

    int n_tests = 0;
    int n_fail  = 0;

    scaler_h_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_in_width (cfg_in_width),
        .cfg_out_width(cfg_out_width),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .de_i         (de_i),
        .vs_i         (vs_i),
        .scale_step_h (scale_step_h),
        .step_upd     (step_upd),
        .pending      (pending),
        .busy         (busy),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one config and wait until it becomes pending.
    task automatic run_cfg(input logic [15:0] iw, input logic [15:0] ow);
        cfg_in_width  = iw;
        cfg_out_width = ow;
        cfg_valid     = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        repeat (DW - 1) tick();
        chk("pending_early", pending, 0);
        tick();
        chk("pending_on_time", pending, 1);
        chk("ready_in_wait", cfg_ready, 0);
    endtask

    task automatic frame_start(input logic [15:0] exp_step);
        de_i = 1'b1;
        vs_i = 1'b1;
        tick();
        de_i = 1'b0;
        vs_i = 1'b0;
        chk("apply_step", scale_step_h, exp_step);
        chk("apply_upd", step_upd, 1);
        chk("apply_pending_clr", pending, 0);
        tick();
        chk("upd_single", step_upd, 0);
        chk("step_hold", scale_step_h, exp_step);
    endtask

    initial begin
        rst_n         = 1'b0;
        cfg_in_width  = '0;
        cfg_out_width = '0;
        cfg_valid     = 1'b0;
        de_i          = 1'b0;
        vs_i          = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_step", scale_step_h, 4096);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_upd", step_upd, 0);

        // 1920 -> 1280: 1.5
        run_cfg(16'd1920, 16'd1280);
        chk("step_before_frame", scale_step_h, 4096);
        frame_start(16'd6144);
        chk("err_ok1", cfg_err, 0);

        // 1280 -> 1920
        run_cfg(16'd1280, 16'd1920);
        frame_start(16'(EXP2));

        // zero output width
        cfg_in_width  = 16'd100;
        cfg_out_width = 16'd0;
        cfg_valid     = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("zero_err", cfg_err, 1);
        chk("zero_busy", busy, 0);
        chk("zero_ready", cfg_ready, 1);
        chk("zero_step", scale_step_h, 16'(EXP2));
        chk("zero_upd", step_upd, 0);

        // saturation; accept clears the old error
        cfg_in_width  = 16'hFFFF;
        cfg_out_width = 16'd1;
        cfg_valid     = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("err_clr_accept", cfg_err, 0);
        repeat (DW) tick();
        chk("sat_pending", pending, 1);
        chk("sat_err", cfg_err, 1);
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
        chk("vs_only_pending", pending, 1);
        chk("vs_only_upd", step_upd, 0);
        chk("vs_only_step", scale_step_h, 16'(EXP2));
        frame_start(16'hFFFF);

        // frame start mid-DIV ignored; held cfg_valid waits for IDLE
        cfg_in_width  = 16'd1920;
        cfg_out_width = 16'd1280;
        cfg_valid     = 1'b1;
        tick();
        chk("err_clr2", cfg_err, 0);
        cfg_in_width  = 16'd1280;
        cfg_out_width = 16'd1920;
        repeat (5) tick();
        de_i = 1'b1;
        vs_i = 1'b1;
        tick();
        de_i = 1'b0;
        vs_i = 1'b0;
        chk("middiv_busy", busy, 1);
        chk("middiv_pending", pending, 0);
        chk("middiv_step", scale_step_h, 16'hFFFF);
        chk("middiv_upd", step_upd, 0);
        repeat (DW - 6) tick();
        chk("held_pending", pending, 1);
        chk("held_ready", cfg_ready, 0);
        de_i = 1'b1;
        vs_i = 1'b1;
        tick();
        de_i = 1'b0;
        vs_i = 1'b0;
        chk("held_apply_step", scale_step_h, 6144);
        chk("held_apply_upd", step_upd, 1);
        chk("held_idle_ready", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        chk("held_accepted", busy, 1);

        // reset during DIV
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rdiv_step", scale_step_h, 4096);
        chk("rdiv_pending", pending, 0);
        chk("rdiv_busy", busy, 0);
        chk("rdiv_ready", cfg_ready, 1);

        // reset during WAIT_FRAME
        run_cfg(16'd1920, 16'd1280);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rwait_step", scale_step_h, 4096);
        chk("rwait_pending", pending, 0);
        chk("rwait_busy", busy, 0);
        chk("rwait_ready", cfg_ready, 1);
        chk("rwait_upd", step_upd, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
